// File: rtl/rotary_paddle_input_pkg.sv
// Shared definitions for the paddle input stage: screen geometry defaults,
// quadrature state encodings and the Gray-step classifier used by the decoder.
package rotary_paddle_input_pkg;

    localparam logic [9:0] NUM_LINES_DEF     = 10'd480;
    localparam logic [9:0] PADDLE_HEIGHT_DEF = 10'd64;

    typedef enum logic [1:0] {
        QUAD_00 = 2'b00,
        QUAD_01 = 2'b01,
        QUAD_11 = 2'b11,
        QUAD_10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_INVALID
    } step_kind_t;

    // Clockwise successor in the Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
    function automatic quad_state_t cw_next(input quad_state_t s);
        quad_state_t n;
        case (s)
            QUAD_00: n = QUAD_01;
            QUAD_01: n = QUAD_11;
            QUAD_11: n = QUAD_10;
            QUAD_10: n = QUAD_00;
            default: n = QUAD_00;
        endcase
        return n;
    endfunction

    function automatic step_kind_t classify_step(input quad_state_t from, input quad_state_t to);
        step_kind_t k;
        if (from == to)
            k = STEP_NONE;
        else if (to == cw_next(from))
            k = STEP_CW;
        else if (from == cw_next(to))
            k = STEP_CCW;
        else
            k = STEP_INVALID;
        return k;
    endfunction

endpackage

// File: rtl/rotary_paddle_input_debounce_filter.sv
// One encoder channel: two-flop synchroniser followed by a mismatch counter that
// only lets the stable level follow the pin after DEBOUNCE_CYCLES steady cycles.
module debounce_filter #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic dout
);

    logic        sync_1;
    logic        sync_2;
    logic [15:0] count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            count  <= 16'd0;
            dout   <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                count <= 16'd0;
            end else if (count == DEBOUNCE_CYCLES - 16'd1) begin
                // The mismatch has now lasted DEBOUNCE_CYCLES samples: accept it.
                dout  <= sync_2;
                count <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/rotary_paddle_input.sv
// Pong paddle input stage: debounced quadrature decoding into detent pulses, a
// saturating per-frame detent accumulator, and a clamped paddle update at vsync fall.
module rotary_paddle_input
    import rotary_paddle_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [9:0]  NUM_LINES       = NUM_LINES_DEF,
    parameter logic [9:0]  PADDLE_HEIGHT   = PADDLE_HEIGHT_DEF,
    parameter logic [9:0]  STEP            = 10'd8,
    parameter logic [9:0]  INIT_POS        = 10'd208
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       rota,
    input  logic       rotb,
    input  logic       vsync,
    output logic [9:0] paddle_y,
    output logic       move_up,
    output logic       move_down
);

    logic stable_a;
    logic stable_b;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_a (
        .Clock (Clock),
        .Reset (Reset),
        .din   (rota),
        .dout  (stable_a)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_b (
        .Clock (Clock),
        .Reset (Reset),
        .din   (rotb),
        .dout  (stable_b)
    );

    quad_state_t       state;
    quad_state_t       state_next;
    quad_state_t       current;
    step_kind_t        step_kind;
    logic signed [2:0] q;
    logic signed [2:0] q_next;
    logic signed [3:0] q_wide;
    logic              up_next;
    logic              down_next;

    assign current = quad_state_t'({stable_a, stable_b});

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= QUAD_00;
            q         <= 3'sd0;
            move_up   <= 1'b0;
            move_down <= 1'b0;
        end else begin
            state     <= state_next;
            q         <= q_next;
            move_up   <= up_next;
            move_down <= down_next;
        end
    end

    // q is evaluated one bit wider so that a fourth CW step reads as +4 rather than wrapping.
    always_comb begin
        state_next = current;
        q_next     = q;
        up_next    = 1'b0;
        down_next  = 1'b0;
        q_wide     = {q[2], q};
        step_kind  = classify_step(state, current);
        case (step_kind)
            STEP_CW:  q_wide = q_wide + 4'sd1;
            STEP_CCW: q_wide = q_wide - 4'sd1;
            default:  q_wide = {q[2], q};
        endcase
        if (step_kind == STEP_CW || step_kind == STEP_CCW) begin
            if (current == QUAD_00) begin
                down_next = (q_wide == 4'sd4);
                up_next   = (q_wide == -4'sd4);
                q_next    = 3'sd0;
            end else begin
                q_next = q_wide[2:0];
            end
        end
    end

    logic signed [3:0]  pending;
    logic signed [3:0]  pending_next;
    logic signed [3:0]  detent;
    logic signed [4:0]  pending_sum;
    logic               vsync_prev;
    logic               strobe;
    logic signed [11:0] pending_wide;
    logic signed [11:0] step_wide;
    logic signed [11:0] pos_wide;
    logic signed [11:0] max_wide;
    logic signed [11:0] new_pos;
    logic [9:0]         clamped_pos;

    assign strobe = vsync_prev & ~vsync;

    always_comb begin
        detent = 4'sd0;
        if (move_down)
            detent = 4'sd1;
        else if (move_up)
            detent = -4'sd1;

        pending_sum = {pending[3], pending} + {detent[3], detent};
        if (pending_sum > 5'sd7)
            pending_next = 4'sd7;
        else if (pending_sum < -5'sd8)
            pending_next = -4'sd8;
        else
            pending_next = pending_sum[3:0];

        // A detent landing on the strobe cycle is carried into the next frame.
        if (strobe)
            pending_next = detent;
    end

    always_comb begin
        pending_wide = {{8{pending[3]}}, pending};
        step_wide    = signed'({2'b00, STEP});
        pos_wide     = signed'({2'b00, paddle_y});
        max_wide     = signed'({2'b00, NUM_LINES - PADDLE_HEIGHT});
        new_pos      = pos_wide + pending_wide * step_wide;
        if (new_pos < 12'sd0)
            clamped_pos = 10'd0;
        else if (new_pos > max_wide)
            clamped_pos = max_wide[9:0];
        else
            clamped_pos = new_pos[9:0];
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            paddle_y   <= INIT_POS;
            pending    <= 4'sd0;
            vsync_prev <= 1'b1;
        end else begin
            vsync_prev <= vsync;
            pending    <= pending_next;
            if (strobe)
                paddle_y <= clamped_pos;
        end
    end

endmodule

// File: tb/tb_rotary_paddle_input.sv
// Directed bench for rotary_paddle_input with a short debounce window; expected
// paddle positions and pulse counts are hand-computed constants.
module tb_rotary_paddle_input;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rota = 1'b0;
    logic       rotb = 1'b0;
    logic       vsync = 1'b1;
    logic [9:0] paddle_y;
    logic       move_up;
    logic       move_down;

    int total = 0;
    int bad = 0;
    int up_count = 0;
    int down_count = 0;

    always #5 clock = ~clock;

    rotary_paddle_input #(
        .DEBOUNCE_CYCLES (16'd4)
    ) dut (
        .Clock     (clock),
        .Reset     (reset_n),
        .rota      (rota),
        .rotb      (rotb),
        .vsync     (vsync),
        .paddle_y  (paddle_y),
        .move_up   (move_up),
        .move_down (move_down)
    );

    always @(negedge clock) begin
        if (move_up === 1'b1)
            up_count++;
        if (move_down === 1'b1)
            down_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input int hold);
        rota = ab[1];
        rotb = ab[0];
        tick(hold);
    endtask

    task automatic detent_cw();
        applyStimulus(2'b01, 8);
        applyStimulus(2'b11, 8);
        applyStimulus(2'b10, 8);
        applyStimulus(2'b00, 8);
    endtask

    task automatic detent_ccw();
        applyStimulus(2'b10, 8);
        applyStimulus(2'b11, 8);
        applyStimulus(2'b01, 8);
        applyStimulus(2'b00, 8);
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(2);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        // Reset state and an idle frame.
        tick(3);
        checkOutput("reset_paddle", 32'(paddle_y), 32'd208);
        checkOutput("reset_up", 32'(move_up), 32'd0);
        checkOutput("reset_down", 32'(move_down), 32'd0);
        reset_n = 1'b1;
        tick(2);
        frame();
        checkOutput("idle_frame", 32'(paddle_y), 32'd208);

        // One CW detent with exact pulse latency.
        applyStimulus(2'b01, 10);
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 10);
        rota = 1'b0;
        rotb = 1'b0;
        tick(6);
        checkOutput("cw_before_latency", 32'(move_down), 32'd0);
        tick(1);
        checkOutput("cw_pulse", 32'(move_down), 32'd1);
        tick(1);
        checkOutput("cw_pulse_width", 32'(move_down), 32'd0);
        tick(5);
        checkOutput("cw_down_count", 32'(down_count), 32'd1);
        checkOutput("cw_up_count", 32'(up_count), 32'd0);
        frame();
        checkOutput("cw_frame", 32'(paddle_y), 32'd216);

        // Short glitches on A must be filtered out.
        for (int i = 0; i < 10; i++) begin
            rota = 1'b1;
            tick(3);
            rota = 1'b0;
            tick(6);
        end
        tick(10);
        frame();
        checkOutput("glitch_paddle", 32'(paddle_y), 32'd216);
        checkOutput("glitch_down", 32'(down_count), 32'd1);
        checkOutput("glitch_up", 32'(up_count), 32'd0);

        // CCW saturation and bottom clamp.
        do_reset();
        checkOutput("t4_reset", 32'(paddle_y), 32'd208);
        repeat (30) detent_ccw();
        checkOutput("t4_up_count", 32'(up_count), 32'd30);
        frame();
        checkOutput("t4_sat_frame", 32'(paddle_y), 32'd144);
        repeat (8) detent_ccw();
        frame();
        checkOutput("t4_frame2", 32'(paddle_y), 32'd80);
        repeat (8) detent_ccw();
        frame();
        checkOutput("t4_frame3", 32'(paddle_y), 32'd16);
        repeat (8) detent_ccw();
        frame();
        checkOutput("t4_clamp_zero", 32'(paddle_y), 32'd0);
        repeat (2) detent_ccw();
        frame();
        checkOutput("t4_stay_zero", 32'(paddle_y), 32'd0);
        checkOutput("t4_up_total", 32'(up_count), 32'd56);

        // CW climb to the top limit.
        for (int f = 1; f <= 7; f++) begin
            repeat (7) detent_cw();
            frame();
            checkOutput("t5_climb", 32'(paddle_y), 32'(56 * f));
        end
        repeat (3) detent_cw();
        frame();
        checkOutput("t5_reach_max", 32'(paddle_y), 32'd416);
        detent_cw();
        frame();
        checkOutput("t5_clamp_max", 32'(paddle_y), 32'd416);
        checkOutput("t5_down_total", 32'(down_count), 32'd54);

        // Detent coinciding with the frame strobe.
        do_reset();
        checkOutput("t6_reset", 32'(paddle_y), 32'd208);
        applyStimulus(2'b01, 8);
        applyStimulus(2'b11, 8);
        applyStimulus(2'b10, 8);
        rota = 1'b0;
        rotb = 1'b0;
        tick(7);
        checkOutput("t6_pulse", 32'(move_down), 32'd1);
        vsync = 1'b0;
        tick(1);
        checkOutput("t6_same_frame", 32'(paddle_y), 32'd208);
        vsync = 1'b1;
        tick(3);
        frame();
        checkOutput("t6_next_frame", 32'(paddle_y), 32'd216);

        // Reset partway through a detent discards the partial count.
        applyStimulus(2'b01, 8);
        applyStimulus(2'b11, 8);
        reset_n = 1'b0;
        tick(3);
        checkOutput("t6_reset_pos", 32'(paddle_y), 32'd208);
        reset_n = 1'b1;
        applyStimulus(2'b11, 10);
        applyStimulus(2'b10, 8);
        applyStimulus(2'b00, 8);
        tick(4);
        checkOutput("t6_no_down", 32'(down_count), 32'd55);
        checkOutput("t6_no_up", 32'(up_count), 32'd56);
        frame();
        checkOutput("t6_final_pos", 32'(paddle_y), 32'd208);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
